// File: rtl/ascon_host_pkg.sv
// Shared definitions for the Ascon host byte-stream controller.
// Holds the opcode nibbles, the core's operation-mode codes, the controller FSM
// state type, the default watchdog length and the opcode legality check.
package ascon_host_pkg;

    localparam int unsigned DefaultTimeoutCyc = 255;

    // Opcode byte is {op[7:4], arg[3:0]}
    localparam logic [3:0] OpNop     = 4'h0;
    localparam logic [3:0] OpWrReg   = 4'h1;
    localparam logic [3:0] OpStart   = 4'h2;
    localparam logic [3:0] OpRdState = 4'h3;
    localparam logic [3:0] OpWrState = 4'h4;
    localparam logic [3:0] OpStatus  = 4'h5;

    // Operation modes, same encoding as the core
    localparam logic [2:0] ModeEnc  = 3'd1;
    localparam logic [2:0] ModeDec  = 3'd2;
    localparam logic [2:0] ModeHash = 3'd3;
    localparam logic [2:0] ModeXof  = 3'd4;
    localparam logic [2:0] ModeCxof = 3'd5;

    typedef enum logic [3:0] {
        StIdle,
        StWrReg,
        StWrStWait,
        StWrStShift,
        StStart,
        StBusy,
        StRdLoad,
        StRdOut,
        StStatOut
    } host_state_e;

    // True when the opcode byte names a supported command with an in-range argument.
    function automatic logic op_legal(input logic [7:0] b);
        logic legal;
        legal = 1'b0;
        case (b[7:4])
            OpNop:                legal = 1'b1;
            OpWrReg:              legal = (b[3:0] <= 4'd2);
            OpStart:              legal = (b[3:0] >= {1'b0, ModeEnc}) &&
                                          (b[3:0] <= {1'b0, ModeCxof});
            OpRdState, OpWrState: legal = (b[3:0] <= 4'd4);
            OpStatus:             legal = (b[3:0] == 4'd0);
            default:              legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/ascon_host_ctrl_bit_ser.sv
// Parallel-to-serial shifter feeding the permutation's state shift port.
// A load captures one byte and a target word select; the byte is then emitted
// over the next 8 cycles, bit 7 first, with shift_en held high.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   load, load_data  start serialising load_data (only while idle)
//   load_sel         state word targeted by this byte
//   last             high in the final (8th) shift cycle
//   shift_en         busy flag, doubles as the state write enable
//   shift_sel        latched word select
//   shift_lsb        current serial bit (0 while idle)
module ascon_bit_ser (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic [2:0] load_sel,
    output logic       last,
    output logic       shift_en,
    output logic [2:0] shift_sel,
    output logic       shift_lsb
);

    logic [7:0] sr_q, sr_d;
    logic [2:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic [2:0] sel_q, sel_d;

    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        sel_d  = sel_q;
        if (load) begin
            sr_d   = load_data;
            cnt_d  = 3'd0;
            busy_d = 1'b1;
            sel_d  = load_sel;
        end else if (busy_q) begin
            sr_d  = {sr_q[6:0], 1'b0};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q   <= 8'd0;
            cnt_q  <= 3'd0;
            busy_q <= 1'b0;
            sel_q  <= 3'd0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            sel_q  <= sel_d;
        end
    end

    assign last      = busy_q && (cnt_q == 3'd7);
    assign shift_en  = busy_q;
    assign shift_sel = sel_q;
    assign shift_lsb = busy_q & sr_q[7];

endmodule

// File: rtl/ascon_host_ctrl.sv
// Byte-stream command controller sequencing the Ascon core.
// Accepts opcode/data bytes from the host, loads the three 128-bit operand
// registers, writes state words serially, launches operations with a watchdog,
// and streams state words / status back to the host.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_data/in_ready       host command byte stream
//   out_valid/out_data/out_ready    response byte stream
//   reg0_128b..reg2_128b            operand registers (key, message, AD)
//   operation_mode/operation_ready  mode and one-cycle start pulse to the core
//   state_shift_en/sel/lsb          serial state write port
//   state_rd_sel/state_rd_data      external state read mux
//   core_done                       completion pulse from the core
module ascon_host_ctrl
    import ascon_host_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DefaultTimeoutCyc
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [7:0]   out_data,
    input  logic         out_ready,
    output logic [127:0] reg0_128b,
    output logic [127:0] reg1_128b,
    output logic [127:0] reg2_128b,
    output logic [2:0]   operation_mode,
    output logic         operation_ready,
    output logic         state_shift_en,
    output logic [2:0]   state_shift_sel,
    output logic         state_shift_lsb,
    output logic [2:0]   state_rd_sel,
    input  logic [63:0]  state_rd_data,
    input  logic         core_done
);

    localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);

    host_state_e    state_q, state_d;
    logic           in_ready_q, in_ready_d;
    logic [127:0]   reg0_q, reg0_d;
    logic [127:0]   reg1_q, reg1_d;
    logic [127:0]   reg2_q, reg2_d;
    logic [2:0]     mode_q, mode_d;
    logic [2:0]     rd_sel_q, rd_sel_d;
    logic [1:0]     widx_q, widx_d;
    logic [2:0]     wsel_q, wsel_d;
    logic [63:0]    snap_q, snap_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           err_q, err_d;
    logic           done_q, done_d;
    logic [WdW-1:0] wdog_q, wdog_d;

    logic accept;
    logic ser_load;
    logic ser_last;

    // in_ready is registered so it stays low through reset and the first clock.
    assign accept = in_valid & in_ready_q;

    always_comb begin
        state_d  = state_q;
        reg0_d   = reg0_q;
        reg1_d   = reg1_q;
        reg2_d   = reg2_q;
        mode_d   = mode_q;
        rd_sel_d = rd_sel_q;
        widx_d   = widx_q;
        wsel_d   = wsel_q;
        snap_d   = snap_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        done_d   = done_q;
        wdog_d   = wdog_q;
        ser_load = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!op_legal(in_data)) begin
                        err_d = 1'b1;
                    end else begin
                        case (in_data[7:4])
                            OpWrReg: begin
                                widx_d  = in_data[1:0];
                                cnt_d   = 4'd0;
                                state_d = StWrReg;
                            end
                            OpStart: begin
                                mode_d  = in_data[2:0];
                                done_d  = 1'b0;
                                state_d = StStart;
                            end
                            OpRdState: begin
                                rd_sel_d = in_data[2:0];
                                state_d  = StRdLoad;
                            end
                            OpWrState: begin
                                wsel_d  = in_data[2:0];
                                cnt_d   = 4'd0;
                                state_d = StWrStWait;
                            end
                            OpStatus: begin
                                // Status byte rides in the top of the response shifter
                                snap_d  = {state_q == StBusy, err_q, done_q, 5'd0, 56'd0};
                                state_d = StStatOut;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            StWrReg: begin
                if (accept) begin
                    case (widx_q)
                        2'd0:    reg0_d = {reg0_q[119:0], in_data};
                        2'd1:    reg1_d = {reg1_q[119:0], in_data};
                        default: reg2_d = {reg2_q[119:0], in_data};
                    endcase
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = StIdle;
                    end
                end
            end
            StWrStWait: begin
                if (accept) begin
                    ser_load = 1'b1;
                    cnt_d    = cnt_q + 4'd1;
                    state_d  = StWrStShift;
                end
            end
            StWrStShift: begin
                if (ser_last) begin
                    state_d = (cnt_q == 4'd8) ? StIdle : StWrStWait;
                end
            end
            StStart: begin
                wdog_d  = '0;
                state_d = StBusy;
            end
            StBusy: begin
                // Completion takes priority over a coincident watchdog expiry
                if (core_done) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (wdog_q == WdW'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    wdog_d = wdog_q + WdW'(1);
                end
            end
            StRdLoad: begin
                snap_d  = state_rd_data;
                cnt_d   = 4'd0;
                state_d = StRdOut;
            end
            StRdOut: begin
                if (out_ready) begin
                    snap_d = {snap_q[55:0], 8'd0};
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        state_d = StIdle;
                    end
                end
            end
            StStatOut: begin
                if (out_ready) begin
                    err_d   = 1'b0;
                    snap_d  = 64'd0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        in_ready_d = (state_d == StIdle) || (state_d == StWrReg) || (state_d == StWrStWait);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            in_ready_q <= 1'b0;
            reg0_q     <= 128'd0;
            reg1_q     <= 128'd0;
            reg2_q     <= 128'd0;
            mode_q     <= 3'd0;
            rd_sel_q   <= 3'd0;
            widx_q     <= 2'd0;
            wsel_q     <= 3'd0;
            snap_q     <= 64'd0;
            cnt_q      <= 4'd0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            reg0_q     <= reg0_d;
            reg1_q     <= reg1_d;
            reg2_q     <= reg2_d;
            mode_q     <= mode_d;
            rd_sel_q   <= rd_sel_d;
            widx_q     <= widx_d;
            wsel_q     <= wsel_d;
            snap_q     <= snap_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            done_q     <= done_d;
            wdog_q     <= wdog_d;
        end
    end

    ascon_bit_ser u_bit_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ser_load),
        .load_data (in_data),
        .load_sel  (wsel_q),
        .last      (ser_last),
        .shift_en  (state_shift_en),
        .shift_sel (state_shift_sel),
        .shift_lsb (state_shift_lsb)
    );

    assign in_ready        = in_ready_q;
    assign out_valid       = (state_q == StRdOut) || (state_q == StStatOut);
    assign out_data        = out_valid ? snap_q[63:56] : 8'd0;
    assign reg0_128b       = reg0_q;
    assign reg1_128b       = reg1_q;
    assign reg2_128b       = reg2_q;
    assign operation_mode  = mode_q;
    assign operation_ready = (state_q == StStart);
    assign state_rd_sel    = rd_sel_q;

endmodule

// File: tb/tb_ascon_host_ctrl.sv
module tb_ascon_host_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic         out_valid;
    logic [7:0]   out_data;
    logic         out_ready;
    logic [127:0] reg0_128b, reg1_128b, reg2_128b;
    logic [2:0]   operation_mode;
    logic         operation_ready;
    logic         state_shift_en;
    logic [2:0]   state_shift_sel;
    logic         state_shift_lsb;
    logic [2:0]   state_rd_sel;
    logic [63:0]  state_rd_data;
    logic         core_done;

    logic [405:0] all_out;
    assign all_out = {in_ready, out_valid, out_data, reg0_128b, reg1_128b, reg2_128b,
                      operation_mode, operation_ready, state_shift_en, state_shift_sel,
                      state_shift_lsb, state_rd_sel};

    always #5 clk = ~clk;

    ascon_host_ctrl #(
        .TIMEOUT_CYC (255)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_ready       (out_ready),
        .reg0_128b       (reg0_128b),
        .reg1_128b       (reg1_128b),
        .reg2_128b       (reg2_128b),
        .operation_mode  (operation_mode),
        .operation_ready (operation_ready),
        .state_shift_en  (state_shift_en),
        .state_shift_sel (state_shift_sel),
        .state_shift_lsb (state_shift_lsb),
        .state_rd_sel    (state_rd_sel),
        .state_rd_data   (state_rd_data),
        .core_done       (core_done)
    );

    // Activity monitor on the inactive edge
    int unsigned rdy_pulses   = 0;
    int unsigned shift_total  = 0;
    int unsigned sel_bad      = 0;
    int unsigned rdy_in_shift = 0;
    logic [63:0] lsb_hist     = 64'd0;

    always @(negedge clk) begin
        if (operation_ready) rdy_pulses++;
        if (state_shift_en) begin
            shift_total++;
            lsb_hist = {lsb_hist[62:0], state_shift_lsb};
            if (state_shift_sel != 3'd3) sel_bad++;
            if (in_ready) rdy_in_shift++;
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("send_ready_%02h", b), 512'(in_ready), 512'(1));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic get_byte(output logic [7:0] b);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("get_valid", 512'(out_valid), 512'(1));
        b = out_data;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic status(input string name, input logic [7:0] exp);
        logic [7:0] b;
        send_byte(8'h50);
        get_byte(b);
        check(name, 512'(b), 512'(exp));
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] exp_stat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int unsigned p0, s0;
        int          n;
        logic [63:0] rd_word;

        in_valid      = 1'b0;
        in_data       = 8'd0;
        out_ready     = 1'b0;
        core_done     = 1'b0;
        state_rd_data = 64'h0123456789ABCDEF;

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 512'(all_out), 512'(0));
        rst_n = 1'b1;
        #1;
        check("in_ready_at_release", 512'(in_ready), 512'(0));
        @(negedge clk);
        check("in_ready_first_clock", 512'(in_ready), 512'(1));

        // Single-byte commands followed by STATUS
        vecs[0] = '{8'h00, 8'h00};
        vecs[1] = '{8'h26, 8'h40};
        vecs[2] = '{8'h35, 8'h40};
        vecs[3] = '{8'h13, 8'h40};
        vecs[4] = '{8'hF0, 8'h40};
        vecs[5] = '{8'h20, 8'h40};
        vecs[6] = '{8'h51, 8'h40};
        vecs[7] = '{8'h45, 8'h40};
        vecs[8] = '{8'h0F, 8'h00};
        p0 = rdy_pulses;
        s0 = shift_total;
        for (int i = 0; i < 9; i++) begin
            send_byte(vecs[i].cmd);
            @(negedge clk);
            check($sformatf("vec%0d_idle", i), 512'(in_ready), 512'(1));
            status($sformatf("vec%0d_status", i), vecs[i].exp_stat);
        end
        check("vec_no_start", 512'(rdy_pulses - p0), 512'(0));
        check("vec_no_shift", 512'(shift_total - s0), 512'(0));

        // WR_REG
        send_byte(8'h10);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        @(negedge clk);
        check("reg0_written", 512'(reg0_128b), 512'(128'h000102030405060708090A0B0C0D0E0F));
        check("reg1_zero", 512'(reg1_128b), 512'(0));
        check("reg2_zero", 512'(reg2_128b), 512'(0));
        send_byte(8'h12);
        for (int i = 0; i < 16; i++) send_byte(8'(8'hA0 + i));
        @(negedge clk);
        check("reg2_written", 512'(reg2_128b), 512'(128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF));
        check("reg0_held", 512'(reg0_128b), 512'(128'h000102030405060708090A0B0C0D0E0F));

        // WR_STATE word 3
        s0 = shift_total;
        send_byte(8'h43);
        send_byte(8'h80);
        for (int i = 0; i < 6; i++) send_byte(8'h00);
        send_byte(8'h01);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("wrst_shift_count", 512'(shift_total - s0), 512'(64));
        check("wrst_lsb_pattern", 512'(lsb_hist), 512'(64'h8000000000000001));
        check("wrst_sel", 512'(sel_bad), 512'(0));
        check("wrst_no_ready", 512'(rdy_in_shift), 512'(0));
        check("wrst_idle", 512'({in_ready, state_shift_en}), 512'(2'b10));

        // START with completion
        p0 = rdy_pulses;
        send_byte(8'h21);
        check("start_pulse", 512'(operation_ready), 512'(1));
        check("start_mode", 512'(operation_mode), 512'(1));
        @(negedge clk);
        check("start_pulse_width", 512'(operation_ready), 512'(0));
        check("busy_not_ready", 512'(in_ready), 512'(0));
        repeat (18) @(negedge clk);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        @(negedge clk);
        check("done_idle", 512'(in_ready), 512'(1));
        status("status_done", 8'h20);
        check("start_one_pulse", 512'(rdy_pulses - p0), 512'(1));

        // START with watchdog expiry
        send_byte(8'h24);
        check("xof_mode", 512'(operation_mode), 512'(4));
        n = 0;
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", 512'(n), 512'(256));
        status("status_timeout", 8'h40);
        status("status_cleared", 8'h00);

        // core_done outside BUSY is ignored
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        status("status_stray_done", 8'h00);

        // core_done on the last watchdog cycle wins
        send_byte(8'h25);
        repeat (255) @(negedge clk);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check("tie_idle", 512'(in_ready), 512'(1));
        status("status_tie", 8'h20);

        // RD_STATE with stalls
        send_byte(8'h32);
        check("rd_sel", 512'(state_rd_sel), 512'(2));
        check("rd_valid_load", 512'(out_valid), 512'(0));
        @(negedge clk);
        check("rd_valid_rise", 512'(out_valid), 512'(1));
        rd_word = 64'h0123456789ABCDEF;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rd_byte%0d", i), 512'({out_valid, out_data}),
                  512'({1'b1, rd_word[63 - 8 * i -: 8]}));
            @(negedge clk);
            check($sformatf("rd_byte%0d_held", i), 512'({out_valid, out_data}),
                  512'({1'b1, rd_word[63 - 8 * i -: 8]}));
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        check("rd_done_idle", 512'({out_valid, in_ready}), 512'(2'b01));

        // Reset in the middle of a WR_REG stream
        send_byte(8'h11);
        for (int i = 0; i < 5; i++) send_byte(8'hFF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_wrreg_outputs", 512'(all_out), 512'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_wrreg_reg1", 512'(reg1_128b), 512'(0));

        // Reset during BUSY
        send_byte(8'h23);
        repeat (10) @(negedge clk);
        p0 = rdy_pulses;
        s0 = shift_total;
        rst_n = 1'b0;
        #1;
        check("reset_busy_outputs", 512'(all_out), 512'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_busy_no_pulse", 512'(rdy_pulses - p0), 512'(0));
        check("reset_busy_no_shift", 512'(shift_total - s0), 512'(0));
        status("status_after_reset", 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
